// File: rtl/pu_fifo_pkg.sv
// Shared defaults and helper types for the pu_fifo read side.
package pu_fifo_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ATTR_WIDTH_DEF = 4;
    localparam int FIFO_SIZE_DEF  = 3;

    // Skid buffer geometry: four entries, 2-bit pointers, 3-bit count (0..4).
    localparam int RD_BUF_DEPTH = 4;
    localparam int RD_PTR_W     = $clog2(RD_BUF_DEPTH);
    localparam int RD_CNT_W     = $clog2(RD_BUF_DEPTH + 1);

    // Width needed to hold an occupancy of 0..depth.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int LEVEL_W_DEF = level_width(FIFO_SIZE_DEF);

    // Per-cycle events seen by the occupancy mirror, encoded as {write, pop}.
    typedef enum logic [1:0] {
        LVL_IDLE = 2'b00,
        LVL_POP  = 2'b01,
        LVL_WR   = 2'b10,
        LVL_BOTH = 2'b11
    } lvl_evt_e;

endpackage

// File: rtl/pu_fifo_rd_buf.sv
// Four-entry circular skid buffer: captures popped pu_fifo words at the tail
// and presents the head on a valid/ready handshake.
module pu_fifo_rd_buf
    import pu_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ATTR_WIDTH = ATTR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_cap,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [ATTR_WIDTH-1:0] i_attr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [ATTR_WIDTH-1:0] o_attr,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [RD_CNT_W-1:0]   o_cnt
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ATTR_WIDTH-1:0] attr;
    } entry_t;

    entry_t              r_mem [RD_BUF_DEPTH];
    logic [RD_PTR_W-1:0] r_wr_ptr;
    logic [RD_PTR_W-1:0] r_rd_ptr;
    logic [RD_CNT_W-1:0] r_cnt;
    logic                w_deq;
    entry_t              w_head;

    assign o_valid = (r_cnt != '0);
    assign o_cnt   = r_cnt;
    assign w_deq   = o_valid && i_ready;

    // Head is forced to zero while empty so stale storage never leaks out.
    assign w_head = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_data = w_head.data;
    assign o_attr = w_head.attr;

    // Tail write of the captured word.
    // NOTE: the storage array has no reset; the head gating above hides its contents until written.
    always_ff @(posedge clk) begin
        if (i_cap) begin
            r_mem[r_wr_ptr] <= '{data: i_data, attr: i_attr};
        end
    end

    // Pointers wrap 3->0 naturally; count tracks capture minus dequeue.
    // NOTE: non-blocking assignments so every register here sees pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (i_cap) begin
                r_wr_ptr <= r_wr_ptr + RD_PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + RD_PTR_W'(1);
            end
            case ({i_cap, w_deq})
                2'b10:   r_cnt <= r_cnt + RD_CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - RD_CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/pu_fifo_reader.sv
// Read-side companion to pu_fifo: mirrors its occupancy from the writer's
// strobe, issues pops only when a word is present and the skid buffer has
// room, and hands words downstream on valid/ready.
module pu_fifo_reader
    import pu_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ATTR_WIDTH = ATTR_WIDTH_DEF,
    parameter int FIFO_SIZE  = FIFO_SIZE_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_mon,
    output logic                              signal_oe,
    input  logic [DATA_WIDTH-1:0]             fifo_data,
    input  logic [ATTR_WIDTH-1:0]             fifo_attr,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic [ATTR_WIDTH-1:0]             out_attr,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [level_width(FIFO_SIZE)-1:0] level,
    output logic                              overflow
);

    localparam int                 LEVEL_W    = level_width(FIFO_SIZE);
    localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(FIFO_SIZE);
    localparam int                 PEND_W     = RD_CNT_W + 1;

    logic [LEVEL_W-1:0]  r_level;
    logic                r_oe;
    logic                r_cap_q;
    logic                r_overflow;
    logic [LEVEL_W-1:0]  w_level_next;
    logic                w_overflow_set;
    logic                w_oe_next;
    logic [PEND_W-1:0]   w_pending;
    logic [RD_CNT_W-1:0] w_buf_cnt;
    lvl_evt_e            w_evt;

    assign w_evt = lvl_evt_e'({wr_mon, r_oe});

    // Next occupancy, overflow detection and the registered pop decision.
    // The decision uses the post-edge occupancy (old level plus this cycle's
    // write minus the pop in flight), so a pop issues the cycle right after a
    // write. Buffer credit counts stored words, the capture in flight and the
    // pop in flight; a dequeue happening now is not credited back.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_level_next   = r_level;
        w_overflow_set = 1'b0;
        case (w_evt)
            LVL_WR: begin
                if (r_level == FULL_LEVEL) begin
                    w_overflow_set = 1'b1;
                end else begin
                    w_level_next = r_level + LEVEL_W'(1);
                end
            end
            LVL_POP: w_level_next = r_level - LEVEL_W'(1);
            default: w_level_next = r_level;
        endcase
        w_pending = PEND_W'(w_buf_cnt) + PEND_W'(r_oe) + PEND_W'(r_cap_q);
        w_oe_next = (w_level_next != '0) && (w_pending < PEND_W'(RD_BUF_DEPTH));
    end

    // Occupancy mirror, pop strobe, capture-in-flight flag and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level    <= '0;
            r_oe       <= 1'b0;
            r_cap_q    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_level <= w_level_next;
            r_oe    <= w_oe_next;
            r_cap_q <= r_oe;
            if (w_overflow_set) begin
                r_overflow <= 1'b1;
            end
        end
    end

    pu_fifo_rd_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .ATTR_WIDTH (ATTR_WIDTH)
    ) u_rd_buf (
        .clk     (clk),
        .rst     (rst),
        .i_cap   (r_cap_q),
        .i_data  (fifo_data),
        .i_attr  (fifo_attr),
        .o_data  (out_data),
        .o_attr  (out_attr),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_cnt   (w_buf_cnt)
    );

    assign signal_oe = r_oe;
    assign level     = r_level;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_pu_fifo_reader.sv
// Self-checking bench for pu_fifo_reader: a behavioural pu_fifo model feeds
// the DUT, a scoreboard queue holds the words expected downstream, a cycle
// table checks latency/stall behaviour, and hand-written sequences cover
// simultaneous events, overflow and reset mid-stream.
module tb_pu_fifo_reader;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int FS = 3;
    localparam int LW = $clog2(FS + 1);
    localparam int NV = 15;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          wr_mon    = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] fifo_data = '0;
    logic [AW-1:0] fifo_attr = '0;
    logic [DW-1:0] in_data   = '0;
    logic [AW-1:0] in_attr   = '0;
    logic          signal_oe;
    logic          out_valid;
    logic          overflow;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_attr;
    logic [LW-1:0] level;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] attr;
    } word_t;

    typedef struct {
        logic          wr;
        logic [DW-1:0] data;
        logic [AW-1:0] attr;
        logic          ready;
        logic          exp_oe;
        logic [LW-1:0] exp_level;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        logic [AW-1:0] exp_attr;
    } vec_t;

    word_t fifo_q[$];
    word_t exp_q[$];
    word_t pend;
    logic  pend_vld = 1'b0;
    word_t held;
    logic  held_vld = 1'b0;
    vec_t  vec [NV];
    int    n_checks = 0;
    int    n_errors = 0;

    always #5 clk = ~clk;

    pu_fifo_reader #(
        .DATA_WIDTH (DW),
        .ATTR_WIDTH (AW),
        .FIFO_SIZE  (FS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_mon    (wr_mon),
        .signal_oe (signal_oe),
        .fifo_data (fifo_data),
        .fifo_attr (fifo_attr),
        .out_data  (out_data),
        .out_attr  (out_attr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int wr, input int data, input int attr, input int rdy,
                                input int oe, input int lvl, input int vld,
                                input int ed, input int ea);
        vec_t v;
        v.wr        = wr[0];
        v.data      = DW'(data);
        v.attr      = AW'(attr);
        v.ready     = rdy[0];
        v.exp_oe    = oe[0];
        v.exp_level = LW'(lvl);
        v.exp_valid = vld[0];
        v.exp_data  = DW'(ed);
        v.exp_attr  = AW'(ea);
        return v;
    endfunction

    // Runs at each falling edge: pu_fifo model, scoreboard and stall monitor.
    task automatic model();
        word_t w;
        if (rst) begin
            fifo_q.delete();
            exp_q.delete();
            pend_vld = 1'b0;
            held_vld = 1'b0;
        end else begin
            // pu_fifo presents the word one cycle after the pop strobe.
            if (pend_vld) begin
                fifo_data = pend.data;
                fifo_attr = pend.attr;
                pend_vld  = 1'b0;
            end
            if (signal_oe) begin
                check("oe_with_level", 32'(level != '0), 32'd1);
                check("pop_nonempty", 32'(fifo_q.size() != 0), 32'd1);
                if (fifo_q.size() != 0) begin
                    pend     = fifo_q.pop_front();
                    pend_vld = 1'b1;
                end
            end
            // Writer side: pu_fifo drops a write when full with no pop.
            if (wr_mon && fifo_q.size() < FS) begin
                w.data = in_data;
                w.attr = in_attr;
                fifo_q.push_back(w);
                exp_q.push_back(w);
            end
            if (held_vld) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", out_data, held.data);
                check("stall_attr", 32'(out_attr), 32'(held.attr));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 32'(out_valid), 32'd0);
                end else begin
                    w = exp_q.pop_front();
                    check("out_data", out_data, w.data);
                    check("out_attr", 32'(out_attr), 32'(w.attr));
                end
            end
            held_vld  = out_valid && !out_ready;
            held.data = out_data;
            held.attr = out_attr;
        end
    endtask

    task automatic to_negedge();
        @(negedge clk);
        model();
    endtask

    task automatic to_posedge();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int d, input int a);
        wr_mon  = 1'b1;
        in_data = DW'(d);
        in_attr = AW'(a);
        to_negedge();
        to_posedge();
        wr_mon = 1'b0;
    endtask

    task automatic idle(input int n);
        wr_mon = 1'b0;
        for (int i = 0; i < n; i++) begin
            to_negedge();
            to_posedge();
        end
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done   = 1'b0;
        wr_mon = 1'b0;
        for (int i = 0; i < budget; i++) begin
            to_negedge();
            done = (exp_q.size() == 0) && !out_valid && !signal_oe;
            to_posedge();
            if (done) break;
        end
        check("drain_within_budget", 32'(done), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Cycle table: single word with ready high, then a three-word stall.
        //            wr data at rdy  oe lvl vld edata eattr
        vec[0]  = mk(1, 11, 3, 1,   0, 0,  0,  0,  0);
        vec[1]  = mk(0,  0, 0, 1,   1, 1,  0,  0,  0);
        vec[2]  = mk(0,  0, 0, 1,   0, 0,  0,  0,  0);
        vec[3]  = mk(0,  0, 0, 1,   0, 0,  1, 11,  3);
        vec[4]  = mk(0,  0, 0, 1,   0, 0,  0,  0,  0);
        vec[5]  = mk(1, 12, 4, 0,   0, 0,  0,  0,  0);
        vec[6]  = mk(1, 13, 5, 0,   1, 1,  0,  0,  0);
        vec[7]  = mk(1, 14, 6, 0,   1, 1,  0,  0,  0);
        vec[8]  = mk(0,  0, 0, 0,   1, 1,  1, 12,  4);
        vec[9]  = mk(0,  0, 0, 0,   0, 0,  1, 12,  4);
        vec[10] = mk(0,  0, 0, 0,   0, 0,  1, 12,  4);
        vec[11] = mk(0,  0, 0, 1,   0, 0,  1, 12,  4);
        vec[12] = mk(0,  0, 0, 1,   0, 0,  1, 13,  5);
        vec[13] = mk(0,  0, 0, 1,   0, 0,  1, 14,  6);
        vec[14] = mk(0,  0, 0, 1,   0, 0,  0,  0,  0);

        // Reset held for two cycles: every output at zero.
        repeat (2) @(posedge clk);
        #1;
        to_negedge();
        check("rst_oe", 32'(signal_oe), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_attr", 32'(out_attr), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        to_posedge();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            to_negedge();
            check("idle_no_oe", 32'(signal_oe), 32'd0);
            to_posedge();
        end

        // Table-driven latency and stall trace.
        for (int i = 0; i < NV; i++) begin
            wr_mon    = vec[i].wr;
            in_data   = vec[i].data;
            in_attr   = vec[i].attr;
            out_ready = vec[i].ready;
            to_negedge();
            check($sformatf("vec%0d_oe", i), 32'(signal_oe), 32'(vec[i].exp_oe));
            check($sformatf("vec%0d_level", i), 32'(level), 32'(vec[i].exp_level));
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vec[i].exp_valid));
            if (vec[i].exp_valid) begin
                check($sformatf("vec%0d_data", i), out_data, vec[i].exp_data);
                check($sformatf("vec%0d_attr", i), 32'(out_attr), 32'(vec[i].exp_attr));
            end
            to_posedge();
        end
        wr_mon = 1'b0;

        // Write 15/7 in the cycle a pop issues with level 1: level stays 1.
        out_ready = 1'b1;
        write_word(29, 1);
        wr_mon  = 1'b1;
        in_data = 15;
        in_attr = 7;
        to_negedge();
        check("simul_pre_level", 32'(level), 32'd1);
        check("simul_pre_oe", 32'(signal_oe), 32'd1);
        to_posedge();
        wr_mon = 1'b0;
        to_negedge();
        check("simul_level_held", 32'(level), 32'd1);
        to_posedge();
        wait_idle(20);

        // Back-to-back burst with ready high: one word per cycle, no overflow.
        for (int i = 0; i < 8; i++) begin
            write_word(int'($urandom()), int'($urandom_range(0, 15)));
        end
        wait_idle(30);
        check("burst_no_overflow", 32'(overflow), 32'd0);
        check("burst_level", 32'(level), 32'd0);

        // Overflow: fill the skid buffer, then four writes with no pops.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) write_word(40 + k, k);
        idle(4);
        to_negedge();
        check("prefill_level", 32'(level), 32'd0);
        check("prefill_head", out_data, 32'd40);
        to_posedge();
        for (int k = 0; k < 4; k++) begin
            wr_mon  = 1'b1;
            in_data = DW'(50 + k);
            in_attr = AW'(4 + k);
            to_negedge();
            check("full_no_oe", 32'(signal_oe), 32'd0);
            to_posedge();
        end
        wr_mon = 1'b0;
        to_negedge();
        check("ovf_level", 32'(level), 32'd3);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_no_oe", 32'(signal_oe), 32'd0);
        to_posedge();
        out_ready = 1'b1;
        wait_idle(40);
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("ovf_drained_level", 32'(level), 32'd0);

        // Reset mid-stream with two words buffered.
        out_ready = 1'b0;
        write_word(70, 1);
        write_word(71, 2);
        idle(5);
        to_negedge();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_head", out_data, 32'd70);
        to_posedge();
        rst = 1'b1;
        #2;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_data", out_data, 32'd0);
        check("async_rst_level", 32'(level), 32'd0);
        check("async_rst_overflow", 32'(overflow), 32'd0);
        check("async_rst_oe", 32'(signal_oe), 32'd0);
        to_negedge();
        to_posedge();
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            to_negedge();
            check("post_rst_no_valid", 32'(out_valid), 32'd0);
            to_posedge();
        end
        write_word(72, 3);
        wait_idle(20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
